// File: rtl/input_port_unit.sv
// Input port front end for a mesh router: flit FIFO, XY route decode,
// reserve/relieve handshake toward the switch controller, crossbar feed.
module input_port_unit #(
    parameter int DATA_WIDTH    = 8,
    parameter int REQUEST_WIDTH = 3,
    parameter int COORD_WIDTH   = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int NODE_X        = 0,
    parameter int NODE_Y        = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     valid_in,
    output logic                     ready_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic                     routeReserveRequestValid,
    output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
    output logic                     routeRelieve,
    input  logic                     routeReserveStatus,
    input  logic                     PortReserved,
    output logic [7:0]               drop_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [COORD_WIDTH-1:0] NX = COORD_WIDTH'(NODE_X);
    localparam logic [COORD_WIDTH-1:0] NY = COORD_WIDTH'(NODE_Y);

    localparam logic [REQUEST_WIDTH-1:0] P_LOCAL = REQUEST_WIDTH'(0);
    localparam logic [REQUEST_WIDTH-1:0] P_NORTH = REQUEST_WIDTH'(1);
    localparam logic [REQUEST_WIDTH-1:0] P_EAST  = REQUEST_WIDTH'(2);
    localparam logic [REQUEST_WIDTH-1:0] P_SOUTH = REQUEST_WIDTH'(3);
    localparam logic [REQUEST_WIDTH-1:0] P_WEST  = REQUEST_WIDTH'(4);

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FWD,
        RELIEVE
    } state_t;

    state_t state, state_n;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic                     fwd_pop;
    logic                     drop;
    logic [DATA_WIDTH-1:0]    head;
    logic [1:0]               head_type;
    logic                     is_head;
    logic                     is_tail;
    logic [COORD_WIDTH-1:0]   dx;
    logic [COORD_WIDTH-1:0]   dy;
    logic [REQUEST_WIDTH-1:0] route;
    logic [REQUEST_WIDTH-1:0] req_q;
    logic [7:0]               drops_q;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign ready_in  = !full;
    assign push      = valid_in && !full;

    assign head      = mem[rd_ptr];
    assign head_type = head[DATA_WIDTH-1:DATA_WIDTH-2];
    assign is_head   = (head_type == T_HEAD) || (head_type == T_SINGLE);
    assign is_tail   = (head_type == T_TAIL) || (head_type == T_SINGLE);
    assign dx        = head[COORD_WIDTH-1:0];
    assign dy        = head[2*COORD_WIDTH-1:COORD_WIDTH];

    assign valid_out = (state == FWD) && !empty && PortReserved;
    assign data_out  = valid_out ? head : '0;
    assign fwd_pop   = valid_out && ready_out;

    // Body/tail at the head while idle has no owning packet: discard it.
    assign drop = (state == IDLE) && !empty &&
                  ((head_type == T_BODY) || (head_type == T_TAIL));
    assign pop  = fwd_pop || drop;

    assign routeReserveRequestValid = (state != IDLE);
    assign routeReserveRequest      = req_q;
    assign routeRelieve             = (state == RELIEVE);
    assign drop_count               = drops_q;

    // X is resolved before Y; coordinates compare unsigned.
    always_comb begin
        route = P_LOCAL;
        if (dx > NX) begin
            route = P_EAST;
        end else if (dx < NX) begin
            route = P_WEST;
        end else if (dy > NY) begin
            route = P_NORTH;
        end else if (dy < NY) begin
            route = P_SOUTH;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (!empty && is_head) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (routeReserveStatus) begin
                    state_n = FWD;
                end
            end
            FWD: begin
                if (fwd_pop && is_tail) begin
                    state_n = RELIEVE;
                end
            end
            RELIEVE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            req_q   <= '0;
            drops_q <= '0;
        end else begin
            state <= state_n;
            if ((state == IDLE) && (state_n == REQ)) begin
                req_q <= route;
            end
            if (drop && (drops_q != 8'hFF)) begin
                drops_q <= drops_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_input_port_unit.sv
// Scoreboard bench for input_port_unit at node (1,1): expected flits and
// routes are queued by stimulus and checked by a negedge monitor.
module tb_input_port_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_out = 1'b0;
    logic       routeReserveRequestValid;
    logic [2:0] routeReserveRequest;
    logic       routeRelieve;
    logic       routeReserveStatus = 1'b0;
    logic       PortReserved = 1'b0;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;
    int relieve_cnt = 0;

    logic [7:0] expq[$];
    logic [2:0] rq[$];

    always #5 clk = ~clk;

    input_port_unit #(
        .DATA_WIDTH(8),
        .REQUEST_WIDTH(3),
        .COORD_WIDTH(2),
        .FIFO_DEPTH(4),
        .NODE_X(1),
        .NODE_Y(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .valid_in(valid_in),
        .ready_in(ready_in),
        .data_out(data_out),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .routeReserveRequestValid(routeReserveRequestValid),
        .routeReserveRequest(routeReserveRequest),
        .routeRelieve(routeRelieve),
        .routeReserveStatus(routeReserveStatus),
        .PortReserved(PortReserved),
        .drop_count(drop_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares outputs against the scoreboard queues.
    logic       prev_rv = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_d = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            prev_rv = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(valid_out), 32'd1);
                chk("hold_data", 32'(data_out), 32'(prev_d));
            end
            if (valid_out && ready_out) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL flit_out: got %h expected none", data_out);
                end else begin
                    chk("flit_out", 32'(data_out), 32'(expq.pop_front()));
                end
            end
            if (routeReserveRequestValid && !prev_rv) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL route: got %0d expected none",
                             routeReserveRequest);
                end else begin
                    chk("route", 32'(routeReserveRequest),
                        32'(rq.pop_front()));
                end
            end
            if (routeRelieve) relieve_cnt++;
            prev_rv = routeReserveRequestValid;
            prev_hold = valid_out && !ready_out;
            prev_d = data_out;
        end
    end

    task automatic send(input logic [7:0] f);
        int n;
        logic acc;
        n = 0;
        data_in = f;
        valid_in = 1'b1;
        do begin
            @(negedge clk);
            acc = ready_in;
            tick();
            n++;
        end while (!acc && n < 50);
        chk("send_accepted", 32'(acc), 32'd1);
        valid_in = 1'b0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!routeReserveRequestValid && n < 30) begin
            tick();
            n++;
        end
        chk("req_raised", 32'(routeReserveRequestValid), 32'd1);
    endtask

    // Grant two cycles after the request appears; leaves bench in FWD.
    task automatic grant();
        wait_req();
        tick();
        tick();
        PortReserved = 1'b1;
        routeReserveStatus = 1'b1;
        tick();
        routeReserveStatus = 1'b0;
    endtask

    task automatic wait_relieve(input int start);
        int n;
        n = 0;
        while (relieve_cnt == start && n < 60) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("relieve_once", 32'(relieve_cnt - start), 32'd1);
    endtask

    task automatic run_single(input logic [7:0] f, input logic [2:0] r);
        int start;
        start = relieve_cnt;
        rq.push_back(r);
        expq.push_back(f);
        send(f);
        grant();
        wait_relieve(start);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   pat[6];
        int   start;
        logic [7:0] pkt[4];
        pat = '{1, 0, 1, 1, 0, 1};
        pkt = '{8'h47, 8'h0A, 8'h0B, 8'h8C};

        tick();
        tick();
        chk("rst_ready_in", 32'(ready_in), 32'd1);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_req_valid", 32'(routeReserveRequestValid), 32'd0);
        chk("rst_req", 32'(routeReserveRequest), 32'd0);
        chk("rst_relieve", 32'(routeRelieve), 32'd0);
        chk("rst_drops", 32'(drop_count), 32'd0);
        rst = 1'b1;
        tick();

        // Single flit to (3,1): East, exact cycle checks
        PortReserved = 1'b1;
        ready_out = 1'b1;
        rq.push_back(3'd2);
        expq.push_back(8'hC7);
        send(8'hC7);
        grant();
        chk("s_valid_out", 32'(valid_out), 32'd1);
        chk("s_data_out", 32'(data_out), 32'hC7);
        tick();
        chk("s_relieve", 32'(routeRelieve), 32'd1);
        chk("s_relieve_vo", 32'(valid_out), 32'd0);
        chk("s_relieve_rv", 32'(routeReserveRequestValid), 32'd1);
        chk("s_relieve_rr", 32'(routeReserveRequest), 32'd2);
        tick();
        chk("s_idle_rv", 32'(routeReserveRequestValid), 32'd0);
        chk("s_idle_relieve", 32'(routeRelieve), 32'd0);

        // Routing sweep
        run_single(8'hC4, 3'd4);
        run_single(8'hCD, 3'd1);
        run_single(8'hC1, 3'd3);
        run_single(8'hC5, 3'd0);
        run_single(8'hC2, 3'd2);

        // 4-flit packet with ready_out toggling
        start = relieve_cnt;
        ready_out = 1'b0;
        rq.push_back(3'd2);
        for (int i = 0; i < 4; i++) expq.push_back(pkt[i]);
        for (int i = 0; i < 4; i++) send(pkt[i]);
        grant();
        for (int i = 0; i < 6; i++) begin
            ready_out = pat[i];
            tick();
        end
        ready_out = 1'b1;
        wait_relieve(start);
        chk("pkt_drained", 32'(expq.size()), 32'd0);

        // Fill FIFO, refused fifth flit, ready after one pop
        start = relieve_cnt;
        ready_out = 1'b0;
        PortReserved = 1'b0;
        rq.push_back(3'd2);
        for (int i = 0; i < 4; i++) expq.push_back(pkt[i]);
        for (int i = 0; i < 4; i++) send(pkt[i]);
        chk("full_ready_in", 32'(ready_in), 32'd0);
        data_in = 8'hFF;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        chk("still_full", 32'(ready_in), 32'd0);
        grant();
        chk("fwd_full", 32'(ready_in), 32'd0);
        ready_out = 1'b1;
        tick();
        chk("ready_after_pop", 32'(ready_in), 32'd1);
        wait_relieve(start);
        chk("fill_drained", 32'(expq.size()), 32'd0);

        // Orphan flits dropped in IDLE
        send(8'h05);
        send(8'h86);
        tick();
        tick();
        chk("drop_count", 32'(drop_count), 32'd2);
        chk("orphan_no_req", 32'(routeReserveRequestValid), 32'd0);
        chk("orphan_empty", 32'(ready_in), 32'd1);

        // Head after orphans requests; reset mid-packet
        PortReserved = 1'b0;
        rq.push_back(3'd2);
        send(8'h43);
        send(8'h11);
        wait_req();
        tick();
        routeReserveStatus = 1'b1;
        tick();
        routeReserveStatus = 1'b0;
        tick();
        chk("fwd_blocked_vo", 32'(valid_out), 32'd0);
        chk("fwd_rv", 32'(routeReserveRequestValid), 32'd1);
        start = relieve_cnt;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mrst_rv", 32'(routeReserveRequestValid), 32'd0);
        chk("mrst_rr", 32'(routeReserveRequest), 32'd0);
        chk("mrst_relieve", 32'(routeRelieve), 32'd0);
        chk("mrst_ready_in", 32'(ready_in), 32'd1);
        chk("mrst_valid_out", 32'(valid_out), 32'd0);
        chk("mrst_drops", 32'(drop_count), 32'd0);
        PortReserved = 1'b1;
        ready_out = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_rv", 32'(routeReserveRequestValid), 32'd0);
        chk("post_rst_vo", 32'(valid_out), 32'd0);
        chk("no_relieve", 32'(relieve_cnt - start), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
